timer_alarm_ctrl: RTL and testbench
===================================

Name: timer_alarm_ctrl

Overview:
Memory-mapped alarm scheduler that sits beside system_timer on the peripheral bus. It consumes the free-running 64-bit microsecond time and manages NUM_ALARMS compare slots, each one-shot or periodic. A round-robin scanner checks one slot per clock. Expiring slots set sticky pending bits, which drive a single masked, registered interrupt line to the core.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..8); slot n occupies addresses n*0x10 .. n*0x10+0x0C
IDX_W, $clog2(NUM_ALARMS) (min 1), scanner index width (derived, not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
address  input  8  byte address within block
write_data  input  32  bus write data
read_data  output  32  bus read data, combinational from address
we  input  1  write strobe, one cycle per access
re  input  1  read strobe; reads have no side effects
time_us  input  64  current microsecond time from system_timer
irq  output  1  registered OR of (pending & irq_mask)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Register map, per slot n at base B = n*0x10:
  - B+0x0 CMP_L, B+0x4 CMP_H: 64-bit compare value.
  - B+0x8 PERIOD: 32-bit reload increment in us.
  - B+0xC CTRL: bit0 EN, bit1 PERIODIC; other bits read 0.
- Global registers:
  - 0x80 STATUS: pending[NUM_ALARMS-1:0]; writing 1 clears a bit.
  - 0x84 IRQ_MASK: RW.
  - 0x88 SCAN_IDX: read-only, current scanner index.
- Any unmapped address reads 0. Writes to unmapped or read-only addresses are ignored.
- Reset: all CMP, PERIOD, CTRL, STATUS, IRQ_MASK and the scanner index are 0. irq=0.
- Scanner: idx increments every cycle and wraps from NUM_ALARMS-1 to 0. It never stalls.
- Hit condition for slot idx: EN=1 and time_us >= CMP, unsigned 64-bit compare.
- On a hit, at the next clock edge:
  - pending[idx] is set.
  - If PERIODIC=1 and PERIOD!=0: CMP <= CMP + zero-extended PERIOD, mod 2^64, and EN stays 1.
  - Otherwise: EN <= 0 (one-shot). A periodic slot with PERIOD=0 behaves as one-shot.
- Missed periods: if CMP+PERIOD is still <= time_us, the slot hits again on its next scan pass. Periods are not skipped and no miss count is kept.
- Detection latency: 1..NUM_ALARMS cycles after time_us first satisfies the compare. irq then rises one cycle after the pending bit is set.
- irq is registered as irq <= |(pending & IRQ_MASK). It follows mask and pending changes with 1-cycle latency.
- Simultaneous events:
  - Bus write to any register of the slot being scanned in the same cycle: the bus write wins and that slot's hit is suppressed for this pass. It is re-evaluated on the next pass.
  - STATUS W1C on bit k while slot k hits: the set wins, and pending[k] stays 1.
  - A CTRL write with EN=0 takes effect immediately. No hit can occur for that slot from the next cycle on.
- 64-bit compare updates: software must clear EN before rewriting CMP_L/CMP_H. Hardware does not interlock the two halves.
- Reset mid-operation: all state returns to reset values asynchronously. Pending alarms are lost and irq deasserts immediately.

Test Plan:
1. One-shot: after reset, time_us=0, CMP0=1000, CTRL0=0x1, IRQ_MASK=0x1. Step time_us to 999: no pending. Step to 1000: pending[0]=1 within 4 cycles, irq=1 one cycle later, CTRL0 reads 0x0. Write STATUS=0x1: irq=0 in 1 cycle.
2. Periodic: CMP1=500, PERIOD1=100, CTRL1=0x3, time_us=500. Slot 1 fires, CMP1 reads 600 and EN stays 1. Set time_us=750: the slot fires again on consecutive passes until CMP1=800. PERIOD1=0 with PERIODIC: fires once and EN clears.
3. Wrap/width: CMP2 = 0xFFFF_FFFF_FFFF_FFF0, PERIOD2=0x20, periodic, time_us=0xFFFF_FFFF_FFFF_FFF0. Fires, and CMP2 wraps to 0x10. CMP_H carry is verified for CMP=0x0000_0000_FFFF_FFF0 with PERIOD=0x20, giving 0x0000_0001_0000_0010.
4. Collisions:
   - W1C on STATUS bit 3 in the hit cycle of slot 3: pending[3] remains 1.
   - CTRL0 write on the cycle SCAN_IDX=0 with a hit pending: no pending set that pass, and the hit is set on the next pass if still enabled.
5. Masking and multi-slot: all 4 slots expire together with IRQ_MASK=0x0. STATUS=0xF, irq=0. Set mask 0x4: irq=1 next cycle. Clear bit 2: irq=0.
6. Reset mid-operation: assert rst_n low while a periodic slot is active and pending=0x5. Immediately irq=0, all registers read 0, SCAN_IDX=0. After release, no alarm fires without reprogramming.

Source files
------------

// File: rtl/timer_alarm_ctrl.sv
// ============================================================================
// timer_alarm_ctrl : round-robin 64-bit alarm scheduler with masked irq
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_alarm_ctrl #(
  parameter int NUM_ALARMS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re,
  input  logic [63:0] time_us,
  output logic        irq
);

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  localparam logic [7:0] ADDR_STATUS   = 8'h80;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h84;
  localparam logic [7:0] ADDR_SCAN_IDX = 8'h88;

  localparam logic [1:0] REG_CMP_L  = 2'd0;
  localparam logic [1:0] REG_CMP_H  = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  logic [63:0]           cmp_q    [NUM_ALARMS];
  logic [63:0]           cmp_d    [NUM_ALARMS];
  logic [31:0]           period_q [NUM_ALARMS];
  logic [31:0]           period_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q, en_d;
  logic [NUM_ALARMS-1:0] periodic_q, periodic_d;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic [NUM_ALARMS-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  irq_q, irq_d;

  logic                  slot_space;
  logic [2:0]            slot_num;
  logic [1:0]            reg_sel;
  logic [NUM_ALARMS-1:0] slot_wr;
  logic [NUM_ALARMS-1:0] hit;

  // Reads are side-effect free, so the read strobe carries no information.
  logic unused_re;
  assign unused_re = re;

  always_comb begin
    slot_num   = address[6:4];
    reg_sel    = address[3:2];
    slot_space = !address[7] && (address[1:0] == 2'b00) &&
                 (int'(slot_num) < NUM_ALARMS);
    for (int n = 0; n < NUM_ALARMS; n++) begin
      slot_wr[n] = we && slot_space && (slot_num == 3'(n));
    end
  end

  // A bus write to the scanned slot suppresses its hit for this pass.
  always_comb begin
    for (int n = 0; n < NUM_ALARMS; n++) begin
      hit[n] = (idx_q == IDX_W'(n)) && en_q[n] &&
               (time_us >= cmp_q[n]) && !slot_wr[n];
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_ALARMS; n++) begin
      cmp_d[n]      = cmp_q[n];
      period_d[n]   = period_q[n];
      en_d[n]       = en_q[n];
      periodic_d[n] = periodic_q[n];

      if (hit[n]) begin
        if (periodic_q[n] && (period_q[n] != 32'd0)) begin
          cmp_d[n] = cmp_q[n] + {32'd0, period_q[n]};
        end else begin
          en_d[n] = 1'b0;
        end
      end

      if (slot_wr[n]) begin
        case (reg_sel)
          REG_CMP_L:  cmp_d[n][31:0]  = write_data;
          REG_CMP_H:  cmp_d[n][63:32] = write_data;
          REG_PERIOD: period_d[n]     = write_data;
          REG_CTRL: begin
            en_d[n]       = write_data[0];
            periodic_d[n] = write_data[1];
          end
          default: ;
        endcase
      end
    end

    // Set beats a same-cycle write-one-to-clear.
    pending_d = pending_q;
    if (we && (address == ADDR_STATUS)) begin
      pending_d = pending_q & ~write_data[NUM_ALARMS-1:0];
    end
    pending_d = pending_d | hit;

    mask_d = mask_q;
    if (we && (address == ADDR_IRQ_MASK)) begin
      mask_d = write_data[NUM_ALARMS-1:0];
    end

    if (idx_q == IDX_W'(NUM_ALARMS - 1)) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IDX_W'(1);
    end

    irq_d = |(pending_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_ALARMS; n++) begin
        cmp_q[n]    <= '0;
        period_q[n] <= '0;
      end
      en_q       <= '0;
      periodic_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_ALARMS; n++) begin
        cmp_q[n]    <= cmp_d[n];
        period_q[n] <= period_d[n];
      end
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    read_data = '0;
    if (slot_space) begin
      for (int n = 0; n < NUM_ALARMS; n++) begin
        if (slot_num == 3'(n)) begin
          case (reg_sel)
            REG_CMP_L:  read_data = cmp_q[n][31:0];
            REG_CMP_H:  read_data = cmp_q[n][63:32];
            REG_PERIOD: read_data = period_q[n];
            REG_CTRL:   read_data = {30'd0, periodic_q[n], en_q[n]};
            default:    read_data = '0;
          endcase
        end
      end
    end else begin
      case (address)
        ADDR_STATUS:   read_data = 32'(pending_q);
        ADDR_IRQ_MASK: read_data = 32'(mask_q);
        ADDR_SCAN_IDX: read_data = 32'(idx_q);
        default:       read_data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_alarm_ctrl.sv
// ============================================================================
// tb_timer_alarm_ctrl : directed self-checking bench for timer_alarm_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [63:0] time_us = '0;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  timer_alarm_ctrl #(.NUM_ALARMS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .we         (we),
    .re         (re),
    .time_us    (time_us),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; write_data = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    address = a; re = 1'b1;
    #1;
    d = read_data; re = 1'b0;
  endtask

  task automatic wait_status(input int b, input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      address = 8'h80;
      #1;
      if (read_data[b]) seen = 1'b1;
    end
  endtask

  task automatic wait_idx(input logic [31:0] want, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      address = 8'h88;
      #1;
      if (read_data == want) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
    rd(8'h80, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h exp 0", d); end
    rd(8'h00, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_cmp0 got %h exp 0", d); end
    rd(8'h84, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mask got %h exp 0", d); end
  endtask

  task automatic test_scanner;
    logic [31:0] d;
    logic [31:0] exp_idx [5];
    exp_idx = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int i = 0; i < 5; i++) begin
      if (i != 0) cycles(1);
      rd(8'h88, d);
      vectors++; if (d !== exp_idx[i]) begin miscompares++; $display("FAIL scan_idx[%0d] got %0d exp %0d", i, d, exp_idx[i]); end
    end
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    bit seen;
    wr(8'h00, 32'd1000);
    wr(8'h0C, 32'h1);
    wr(8'h84, 32'h1);
    time_us = 64'd999;
    cycles(8);
    rd(8'h80, d);
    vectors++; if (d !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_early status %h irq %b exp 0 0", d, irq); end
    time_us = 64'd1000;
    wait_status(0, 4, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL oneshot_latency pending0 got 0 exp 1 within 4"); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_lag got %b exp 0", irq); end
    cycles(1);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL oneshot_irq got %b exp 1", irq); end
    rd(8'h0C, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL oneshot_ctrl got %h exp 0", d); end
    wr(8'h80, 32'h1);
    cycles(1);
    rd(8'h80, d);
    vectors++; if (irq !== 1'b0 || d !== 32'h0) begin miscompares++; $display("FAIL oneshot_clear irq %b status %h exp 0 0", irq, d); end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    bit seen;
    time_us = 64'd0;
    wr(8'h10, 32'd500);
    wr(8'h14, 32'd0);
    wr(8'h18, 32'd100);
    wr(8'h1C, 32'h3);
    time_us = 64'd500;
    wait_status(1, 8, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL periodic_fire pending1 got 0 exp 1"); end
    cycles(4);
    rd(8'h10, d);
    vectors++; if (d !== 32'd600) begin miscompares++; $display("FAIL periodic_reload got %0d exp 600", d); end
    rd(8'h1C, d);
    vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL periodic_ctrl got %h exp 3", d); end
    wr(8'h80, 32'h2);
    time_us = 64'd750;
    cycles(16);
    rd(8'h10, d);
    vectors++; if (d !== 32'd800) begin miscompares++; $display("FAIL periodic_catchup got %0d exp 800", d); end
    rd(8'h80, d);
    vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL periodic_catchup_status got %h exp 2", d); end
    wr(8'h18, 32'd0);
    wr(8'h80, 32'h2);
    time_us = 64'd800;
    cycles(8);
    rd(8'h80, d);
    vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL period0_fire got %h exp 2", d); end
    rd(8'h1C, d);
    vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL period0_ctrl got %h exp 2", d); end
    rd(8'h10, d);
    vectors++; if (d !== 32'd800) begin miscompares++; $display("FAIL period0_cmp got %0d exp 800", d); end
    wr(8'h80, 32'h2);
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    logic [31:0] h;
    bit seen;
    time_us = 64'd0;
    wr(8'h20, 32'hFFFF_FFF0);
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h28, 32'h20);
    wr(8'h2C, 32'h3);
    time_us = 64'hFFFF_FFFF_FFFF_FFF0;
    wait_status(2, 4, seen);
    wr(8'h2C, 32'h2);
    vectors++; if (!seen) begin miscompares++; $display("FAIL wrap_fire pending2 got 0 exp 1"); end
    rd(8'h20, d);
    rd(8'h24, h);
    vectors++; if ({h, d} !== 64'h10) begin miscompares++; $display("FAIL wrap_cmp got %h%h exp 0000000000000010", h, d); end
    wr(8'h80, 32'h4);
    time_us = 64'd0;
    wr(8'h20, 32'hFFFF_FFF0);
    wr(8'h24, 32'h0);
    wr(8'h2C, 32'h3);
    time_us = 64'h0000_0000_FFFF_FFF0;
    wait_status(2, 4, seen);
    cycles(4);
    rd(8'h20, d);
    rd(8'h24, h);
    vectors++; if ({h, d} !== 64'h0000_0001_0000_0010) begin miscompares++; $display("FAIL carry_cmp got %h%h exp 0000000100000010", h, d); end
    rd(8'h2C, d);
    vectors++; if (d !== 32'h3) begin miscompares++; $display("FAIL carry_ctrl got %h exp 3", d); end
    wr(8'h2C, 32'h0);
    wr(8'h80, 32'h4);
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    bit seen;
    time_us = 64'd0;
    wr(8'h30, 32'd100);
    wr(8'h34, 32'd0);
    wr(8'h3C, 32'h1);
    wait_idx(32'd3, seen);
    time_us = 64'd100;
    address = 8'h80; write_data = 32'h8; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd(8'h80, d);
    vectors++; if (!seen || d !== 32'h8) begin miscompares++; $display("FAIL w1c_vs_set status got %h exp 8 (idx_found=%0d)", d, seen); end
    wr(8'h80, 32'h8);

    time_us = 64'd0;
    wr(8'h00, 32'd200);
    wr(8'h04, 32'd0);
    wr(8'h0C, 32'h1);
    wait_idx(32'd0, seen);
    time_us = 64'd200;
    address = 8'h0C; write_data = 32'h1; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd(8'h80, d);
    vectors++; if (!seen || d !== 32'h0) begin miscompares++; $display("FAIL wr_suppress status got %h exp 0 (idx_found=%0d)", d, seen); end
    cycles(3);
    rd(8'h80, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL wr_suppress_hold status got %h exp 0", d); end
    cycles(1);
    rd(8'h80, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL wr_next_pass status got %h exp 1", d); end
    rd(8'h0C, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL wr_next_pass_ctrl got %h exp 0", d); end
    wr(8'h80, 32'h1);
  endtask

  task automatic test_mask_multi;
    logic [31:0] d;
    wr(8'h84, 32'h0);
    time_us = 64'd0;
    for (int n = 0; n < 4; n++) begin
      wr(8'(n * 16), 32'd300);
      wr(8'(n * 16 + 4), 32'd0);
      wr(8'(n * 16 + 12), 32'h1);
    end
    time_us = 64'd300;
    cycles(8);
    rd(8'h80, d);
    vectors++; if (d !== 32'hF) begin miscompares++; $display("FAIL multi_status got %h exp F", d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL masked_irq got %b exp 0", irq); end
    wr(8'h84, 32'h4);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mask_latency got %b exp 0", irq); end
    cycles(1);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL mask_irq got %b exp 1", irq); end
    wr(8'h80, 32'h4);
    cycles(1);
    rd(8'h80, d);
    vectors++; if (irq !== 1'b0 || d !== 32'hB) begin miscompares++; $display("FAIL mask_clear irq %b status %h exp 0 B", irq, d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [7:0]  regs [6];
    regs = '{8'h80, 8'h84, 8'h2C, 8'h20, 8'h28, 8'h88};
    wr(8'h80, 32'hF);
    wr(8'h84, 32'h5);
    time_us = 64'd0;
    wr(8'h00, 32'd400);
    wr(8'h0C, 32'h1);
    wr(8'h20, 32'd400);
    wr(8'h28, 32'd1000);
    wr(8'h2C, 32'h3);
    time_us = 64'd400;
    cycles(8);
    rd(8'h80, d);
    vectors++; if (d !== 32'h5 || irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset status %h irq %b exp 5 1", d, irq); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL async_reset_irq got %b exp 0", irq); end
    for (int i = 0; i < 6; i++) begin
      rd(regs[i], d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_reg[%h] got %h exp 0", regs[i], d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(8);
    rd(8'h80, d);
    vectors++; if (d !== 32'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL post_reset status %h irq %b exp 0 0", d, irq); end
  endtask

  initial begin
    test_reset();
    test_scanner();
    test_one_shot();
    test_periodic();
    test_wrap();
    test_collisions();
    test_mask_multi();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
